// File: rtl/unary_acc_pkg.sv
// Shared types and helpers for the unary window accumulator.
// State encoding for the window FSM and the all-ones clamp value for a given width.
package unary_acc_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } acc_state_t;

   // All-ones value of the given width, usable in constant expressions.
   function automatic logic [63:0] sat_max(input int unsigned width);
      if (width >= 64)
         return {64{1'b1}};
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulation channel: running sum, saturating or wrapping adder, sticky overflow flag.
// Latency: sum_nxt/ovf_nxt are combinational and include the current beat; registers update on add_en.
// Backpressure: none of its own; the parent gates add_en and restart.
module acc_lane
   import unary_acc_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int ACC_WIDTH  = 8,
   parameter int SATURATE   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  add_en,
   input  logic                  restart,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [ACC_WIDTH-1:0]  acc,
   output logic                  ovf,
   output logic [ACC_WIDTH-1:0]  sum_nxt,
   output logic                  ovf_nxt
);

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));

   logic [ACC_WIDTH:0] wide_sum;
   logic               carry;

   // The extra top bit is the carry; it marks the true sum passing ACC_MAX.
   always_comb begin
      wide_sum = {1'b0, acc} + (ACC_WIDTH+1)'(data);
      carry    = wide_sum[ACC_WIDTH];
      if (SATURATE != 0 && carry)
         sum_nxt = ACC_MAX;
      else
         sum_nxt = wide_sum[ACC_WIDTH-1:0];
      ovf_nxt  = ovf | carry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (clear || restart) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (add_en) begin
         acc <= sum_nxt;
         ovf <= ovf_nxt;
      end
   end

endmodule

// File: rtl/unary_window_acc.sv
// Per-channel windowed accumulator: one packed result per WINDOW accepted beats.
// Latency: result valid 1 cycle after the accepting edge of the window's last beat.
// Backpressure: if the result register is still occupied at window end, in_ready drops (HOLD) until it drains.
module unary_window_acc
   import unary_acc_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 1,
   parameter int ACC_WIDTH  = 8,
   parameter int WINDOW     = 255,
   parameter int SATURATE   = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   data_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUM_CH*ACC_WIDTH-1:0]    acc_out,
   output logic [NUM_CH-1:0]              out_ovf,
   output logic [$clog2(WINDOW+1)-1:0]    beat_cnt
);

   localparam int CNT_W = $clog2(WINDOW+1);

   generate
      if (WINDOW < 1 || NUM_CH < 1 || ACC_WIDTH < DATA_WIDTH) begin : g_bad_params
         $error("unary_window_acc: need WINDOW>=1, NUM_CH>=1, ACC_WIDTH>=DATA_WIDTH");
      end
   endgenerate

   acc_state_t state_q, state_d;

   logic accept, last_beat, out_free, load_beat, load_held, go_hold, restart;
   logic [NUM_CH*ACC_WIDTH-1:0] lane_acc, lane_sum;
   logic [NUM_CH-1:0]           lane_ovf, lane_ovf_nxt;

   assign accept    = in_valid && in_ready && !clear;
   assign last_beat = accept && (beat_cnt == CNT_W'(WINDOW - 1));
   assign out_free  = !out_valid || out_ready;
   assign load_beat = last_beat && out_free;
   assign go_hold   = last_beat && !out_free;
   // In HOLD the result register is always occupied, so draining it frees the held sums.
   assign load_held = (state_q == ST_HOLD) && out_valid && out_ready && !clear;
   assign restart   = load_beat || load_held;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_ACCUM;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_ACCUM;
      end else begin
         case (state_q)
            ST_ACCUM: if (go_hold)   state_d = ST_HOLD;
            ST_HOLD:  if (load_held) state_d = ST_ACCUM;
            default:                 state_d = ST_ACCUM;
         endcase
      end
   end

   always_comb begin
      in_ready = (state_q == ST_ACCUM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         beat_cnt <= '0;
      else if (clear || restart)
         beat_cnt <= '0;
      else if (accept)
         beat_cnt <= beat_cnt + CNT_W'(1);
   end

   // A fresh load in the same cycle as a drain keeps out_valid high: no bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         acc_out   <= '0;
         out_ovf   <= '0;
      end else if (clear) begin
         out_valid <= 1'b0;
         acc_out   <= '0;
         out_ovf   <= '0;
      end else if (load_beat) begin
         out_valid <= 1'b1;
         acc_out   <= lane_sum;
         out_ovf   <= lane_ovf_nxt;
      end else if (load_held) begin
         out_valid <= 1'b1;
         acc_out   <= lane_acc;
         out_ovf   <= lane_ovf;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
         acc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SATURATE   (SATURATE)
         ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .add_en  (accept),
            .restart (restart),
            .data    (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
            .acc     (lane_acc[c*ACC_WIDTH +: ACC_WIDTH]),
            .ovf     (lane_ovf[c]),
            .sum_nxt (lane_sum[c*ACC_WIDTH +: ACC_WIDTH]),
            .ovf_nxt (lane_ovf_nxt[c])
         );
      end
   endgenerate

endmodule

// File: tb/tb_unary_window_acc.sv
// Scoreboard bench for unary_window_acc across several parameter sets.
// Expected results are hand-computed constants queued at stimulus time and popped by per-instance monitors.
module tb_unary_window_acc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, clear;
   logic [3:0] din;
   logic       va, vbc, vd, ve, ra, rbc, rd, re;

   logic ina, ova; logic [31:0] acca; logic [3:0] ofa, bca;
   logic inb, ovb; logic [11:0] accb; logic [3:0] ofb, bcb;
   logic inc, ovc; logic [11:0] accc; logic [3:0] ofc, bcc;
   logic ind, ovd; logic [31:0] accd; logic [3:0] ofd; logic [2:0] bcd;
   logic ine, ove; logic [31:0] acce; logic [3:0] ofe; logic [0:0] bce;

   int nchk = 0;
   int nerr = 0;

   logic [35:0] qa[$], qd[$], qe[$];
   logic [15:0] qb[$], qc[$];

   logic [7:0] p0, p1, p2, p3;
   logic [3:0] ev [6];

   unary_window_acc #(.NUM_CH(4), .DATA_WIDTH(1), .ACC_WIDTH(8), .WINDOW(8), .SATURATE(1)) u_a (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(va), .in_ready(ina), .data_in(din),
      .out_valid(ova), .out_ready(ra), .acc_out(acca), .out_ovf(ofa), .beat_cnt(bca));

   unary_window_acc #(.NUM_CH(4), .DATA_WIDTH(1), .ACC_WIDTH(3), .WINDOW(10), .SATURATE(1)) u_b (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(vbc), .in_ready(inb), .data_in(din),
      .out_valid(ovb), .out_ready(rbc), .acc_out(accb), .out_ovf(ofb), .beat_cnt(bcb));

   unary_window_acc #(.NUM_CH(4), .DATA_WIDTH(1), .ACC_WIDTH(3), .WINDOW(10), .SATURATE(0)) u_c (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(vbc), .in_ready(inc), .data_in(din),
      .out_valid(ovc), .out_ready(rbc), .acc_out(accc), .out_ovf(ofc), .beat_cnt(bcc));

   unary_window_acc #(.NUM_CH(4), .DATA_WIDTH(1), .ACC_WIDTH(8), .WINDOW(4), .SATURATE(1)) u_d (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(vd), .in_ready(ind), .data_in(din),
      .out_valid(ovd), .out_ready(rd), .acc_out(accd), .out_ovf(ofd), .beat_cnt(bcd));

   unary_window_acc #(.NUM_CH(4), .DATA_WIDTH(1), .ACC_WIDTH(8), .WINDOW(1), .SATURATE(1)) u_e (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(ve), .in_ready(ine), .data_in(din),
      .out_valid(ove), .out_ready(re), .acc_out(acce), .out_ovf(ofe), .beat_cnt(bce));

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic unexpected(input string name);
      nchk++;
      nerr++;
      $display("FAIL %s_unexpected: result presented with no expected entry queued", name);
   endtask

   function automatic logic [35:0] exp_e(input logic [3:0] d);
      return {4'h0, 7'd0, d[3], 7'd0, d[2], 7'd0, d[1], 7'd0, d[0]};
   endfunction

   task automatic beat_a(input logic [3:0] d);
      va = 1'b1; din = d;
      @(posedge clk); #1;
      va = 1'b0;
   endtask

   task automatic beat_bc(input logic [3:0] d);
      vbc = 1'b1; din = d;
      @(posedge clk); #1;
      vbc = 1'b0;
   endtask

   task automatic beat_d(input logic [3:0] d);
      vd = 1'b1; din = d;
      @(posedge clk); #1;
      vd = 1'b0;
   endtask

   // Monitors: a result is consumed on any cycle with out_valid && out_ready.
   always @(negedge clk) if (!rst && ova && ra) begin
      if (qa.size() == 0) unexpected("a");
      else chk("a_result", 64'({ofa, acca}), 64'(qa.pop_front()));
   end
   always @(negedge clk) if (!rst && ovb && rbc) begin
      if (qb.size() == 0) unexpected("b");
      else chk("b_result", 64'({ofb, accb}), 64'(qb.pop_front()));
   end
   always @(negedge clk) if (!rst && ovc && rbc) begin
      if (qc.size() == 0) unexpected("c");
      else chk("c_result", 64'({ofc, accc}), 64'(qc.pop_front()));
   end
   always @(negedge clk) if (!rst && ovd && rd) begin
      if (qd.size() == 0) unexpected("d");
      else chk("d_result", 64'({ofd, accd}), 64'(qd.pop_front()));
   end
   always @(negedge clk) if (!rst && ove && re) begin
      if (qe.size() == 0) unexpected("e");
      else chk("e_result", 64'({ofe, acce}), 64'(qe.pop_front()));
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; clear = 1'b0; din = '0;
      va = 1'b0; vbc = 1'b0; vd = 1'b0; ve = 1'b0;
      ra = 1'b1; rbc = 1'b1; rd = 1'b0; re = 1'b1;
      p0 = 8'hFF; p1 = 8'h0F; p2 = 8'h01; p3 = 8'h00;
      ev = '{4'h1, 4'hA, 4'h5, 4'hF, 4'h0, 4'h6};

      // Reset state
      #1;
      chk("rst_a_valid", 64'(ova), 64'd0);
      chk("rst_a_acc",   64'(acca), 64'd0);
      chk("rst_a_ovf",   64'(ofa), 64'd0);
      chk("rst_a_cnt",   64'(bca), 64'd0);
      chk("rst_d_valid", 64'(ovd), 64'd0);
      #21 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_a_ready", 64'(ina), 64'd1);
      chk("rst_d_ready", 64'(ind), 64'd1);

      // Lane patterns 0xFF/0x0F/0x01/0x00 over an 8-beat window
      qa.push_back({4'h0, 32'h00_01_04_08});
      for (int b = 0; b < 8; b++) begin
         beat_a({p3[b], p2[b], p1[b], p0[b]});
         if (b == 6) chk("t1_cnt7", 64'(bca), 64'd7);
      end
      chk("t1_valid_pulse", 64'(ova), 64'd1);
      chk("t1_cnt_restart", 64'(bca), 64'd0);
      @(posedge clk); #1;
      chk("t1_valid_drop", 64'(ova), 64'd0);

      // 3-bit accumulators, 10-beat windows: saturate vs wrap, and exact-max boundary
      qb.push_back({4'hF, 12'hFFF});
      qc.push_back({4'hF, 12'h492});
      repeat (10) beat_bc(4'hF);
      qb.push_back({4'b1001, 12'hE3F});
      qc.push_back({4'b1001, 12'h03A});
      for (int b = 0; b < 10; b++) beat_bc({b < 8, 1'b0, b < 7, 1'b1});
      @(posedge clk); #1;

      // Two windows against a stalled consumer -> HOLD
      qd.push_back({4'h0, 32'h04040404});
      qd.push_back({4'h0, 32'h00000004});
      rd = 1'b0;
      repeat (4) beat_d(4'hF);
      repeat (4) beat_d(4'h1);
      chk("t3_hold_ready", 64'(ind), 64'd0);
      chk("t3_hold_valid", 64'(ovd), 64'd1);
      chk("t3_first_acc",  64'(accd), 64'h04040404);
      chk("t3_hold_cnt",   64'(bcd), 64'd4);
      repeat (3) @(posedge clk); #1;
      chk("t3_stable_acc", 64'(accd), 64'h04040404);
      vd = 1'b1; din = 4'hF;
      @(posedge clk); #1;
      chk("t3_reject_cnt", 64'(bcd), 64'd4);
      vd = 1'b0; rd = 1'b1;
      @(posedge clk); #1;
      chk("t3_second_valid", 64'(ovd), 64'd1);
      chk("t3_second_acc",   64'(accd), 64'h00000004);
      chk("t3_ready_back",   64'(ind), 64'd1);
      chk("t3_cnt_cleared",  64'(bcd), 64'd0);
      @(posedge clk); #1;
      chk("t3_valid_drop", 64'(ovd), 64'd0);

      // Clear mid-window with a beat offered; also flushes a pending result on D
      rd = 1'b0;
      repeat (4) beat_d(4'hF);
      chk("t4_d_pending", 64'(ovd), 64'd1);
      beat_a(4'hF);
      beat_a(4'hF);
      chk("t4_cnt2", 64'(bca), 64'd2);
      clear = 1'b1; va = 1'b1; din = 4'hF;
      @(posedge clk); #1;
      clear = 1'b0; va = 1'b0;
      chk("t4_clear_cnt",   64'(bca), 64'd0);
      chk("t4_clear_dval",  64'(ovd), 64'd0);
      chk("t4_clear_dacc",  64'(accd), 64'd0);
      chk("t4_clear_ready", 64'(ind), 64'd1);
      qa.push_back({4'h0, 32'h00000808});
      repeat (8) beat_a(4'b0011);
      @(posedge clk); #1;

      // Asynchronous reset mid-window on A and during HOLD on D
      repeat (8) beat_d(4'h2);
      chk("t5_d_in_hold", 64'(ind), 64'd0);
      repeat (3) beat_a(4'hF);
      chk("t5_a_cnt3", 64'(bca), 64'd3);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("t5_rst_a_valid", 64'(ova), 64'd0);
      chk("t5_rst_a_acc",   64'(acca), 64'd0);
      chk("t5_rst_a_cnt",   64'(bca), 64'd0);
      chk("t5_rst_d_valid", 64'(ovd), 64'd0);
      chk("t5_rst_d_acc",   64'(accd), 64'd0);
      chk("t5_rst_d_cnt",   64'(bcd), 64'd0);
      chk("t5_rst_d_ready", 64'(ind), 64'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      rd = 1'b1;
      qa.push_back({4'h0, 32'h08000000});
      repeat (8) beat_a(4'b1000);
      qd.push_back({4'h0, 32'h00040000});
      repeat (4) beat_d(4'b0100);
      @(posedge clk); #1;

      // WINDOW=1 streaming: one result per cycle, no bubbles
      ve = 1'b1;
      for (int i = 0; i < 6; i++) begin
         din = ev[i];
         qe.push_back(exp_e(ev[i]));
         @(posedge clk); #1;
         chk("t6_no_bubble", 64'(ove), 64'd1);
      end
      ve = 1'b0;
      @(posedge clk); #1;
      chk("t6_valid_drop", 64'(ove), 64'd0);

      repeat (3) @(posedge clk); #1;
      chk("end_qa_empty", 64'(qa.size()), 64'd0);
      chk("end_qb_empty", 64'(qb.size()), 64'd0);
      chk("end_qc_empty", 64'(qc.size()), 64'd0);
      chk("end_qd_empty", 64'(qd.size()), 64'd0);
      chk("end_qe_empty", 64'(qe.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
